// File: rtl/param_alu.sv
// Parametrised handshaked ALU: single-cycle ADD/SUB/XOR/AND/OR/PASSB and an
// iterative shift-add unsigned MUL that is built only when ALU_MUL_EN is defined.
module param_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             use_acc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] acc_out,
    output logic [WIDTH-1:0] mul_acc_out,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_XOR   = 3'b010;
    localparam logic [2:0] OP_AND   = 3'b011;
    localparam logic [2:0] OP_OR    = 3'b100;
    localparam logic [2:0] OP_PASSB = 3'b110;

    typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

    state_t           state;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] opa, opb;

    logic [WIDTH:0]   sum_add, sum_sub;
    logic [WIDTH-1:0] res;
    logic             res_c, res_v, res_ok;

    assign sum_add = {1'b0, opa} + {1'b0, opb};
    assign sum_sub = {1'b0, opa} + {1'b0, ~opb} + (WIDTH+1)'(1);

    always_comb begin
        res    = '0;
        res_c  = 1'b0;
        res_v  = 1'b0;
        res_ok = 1'b1;
        case (op_q)
            OP_ADD: begin
                res   = sum_add[WIDTH-1:0];
                res_c = sum_add[WIDTH];
                res_v = (opa[WIDTH-1] == opb[WIDTH-1]) && (res[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_SUB: begin
                res   = sum_sub[WIDTH-1:0];
                res_c = sum_sub[WIDTH];
                res_v = (opa[WIDTH-1] != opb[WIDTH-1]) && (res[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_XOR:   res = opa ^ opb;
            OP_AND:   res = opa & opb;
            OP_OR:    res = opa | opb;
            OP_PASSB: res = opb;
            default:  res_ok = 1'b0;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam int         CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // prod holds {partial high, remaining multiplier bits}; it shifts right
    // once per iteration so prod[0] is always the current multiplier bit.
    logic [2*WIDTH-1:0] prod;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     psum;

    assign psum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opa} : '0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            op_q        <= '0;
            opa         <= '0;
            opb         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            acc_out     <= '0;
            mul_acc_out <= '0;
            carry       <= 1'b0;
            overflow    <= 1'b0;
            zero        <= 1'b0;
`ifdef ALU_MUL_EN
            prod        <= '0;
            cnt         <= '0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q <= op;
                        opa  <= use_acc ? acc_out : a;
                        opb  <= b;
                        busy <= 1'b1;
`ifdef ALU_MUL_EN
                        prod <= {{WIDTH{1'b0}}, b};
                        cnt  <= '0;
                        state <= (op == OP_MUL) ? MUL : EXEC;
`else
                        state <= EXEC;
`endif
                    end
                end
`ifdef ALU_MUL_EN
                MUL: begin
                    prod <= {psum, prod[WIDTH-1:1]};
                    cnt  <= cnt + CW'(1);
                    // Write-back happens in EXEC, giving WIDTH+1 busy cycles.
                    if (cnt == CW'(WIDTH-1))
                        state <= EXEC;
                end
`endif
                EXEC: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
`ifdef ALU_MUL_EN
                    if (op_q == OP_MUL) begin
                        {mul_acc_out, acc_out} <= prod;
                        carry    <= 1'b0;
                        overflow <= 1'b0;
                        zero     <= (prod == '0);
                    end else
`endif
                    if (res_ok) begin
                        acc_out     <= res;
                        mul_acc_out <= '0;
                        carry       <= res_c;
                        overflow    <= res_v;
                        zero        <= (res == '0);
                    end else begin
                        err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_param_alu.sv
// Directed self-checking bench for param_alu (WIDTH=16); MUL checks are
// compiled when ALU_MUL_EN is defined, otherwise op=101 is checked as reserved.
module tb_param_alu;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic         use_acc = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, err, carry, overflow, zero;
    logic [W-1:0] acc_out, mul_acc_out;

    int n_cmp = 0;
    int n_bad = 0;
    logic seen;

    param_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .use_acc(use_acc),
        .a(a), .b(b), .busy(busy), .done(done), .err(err),
        .acc_out(acc_out), .mul_acc_out(mul_acc_out),
        .carry(carry), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for exactly one edge; returns 1ns after that edge.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic ua);
        op = o; a = av; b = bv; use_acc = ua; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        #12;
        chk("reset_ctl",   {busy, done, err}, 3'b000);
        chk("reset_acc",   acc_out, 16'h0000);
        chk("reset_mul",   mul_acc_out, 16'h0000);
        chk("reset_flags", {carry, overflow, zero}, 3'b000);
        rst = 1'b1;
        step();

        issue(3'b000, 16'h7FFF, 16'h0001, 1'b0);
        chk("add_busy_k",  {busy, done}, 2'b10);
        step();
        chk("add_done",    {busy, done, err}, 3'b010);
        chk("add_acc",     acc_out, 16'h8000);
        chk("add_flags",   {carry, overflow, zero}, 3'b010);
        step();
        chk("add_done_1cy", done, 1'b0);
        chk("add_hold",    acc_out, 16'h8000);

        issue(3'b001, 16'h0005, 16'h0005, 1'b0);
        step();
        chk("sub_eq_acc",   acc_out, 16'h0000);
        chk("sub_eq_flags", {carry, overflow, zero}, 3'b101);
        issue(3'b001, 16'h0003, 16'h0005, 1'b0);
        step();
        chk("sub_lt_acc",   acc_out, 16'hFFFE);
        chk("sub_lt_flags", {carry, overflow, zero}, 3'b000);

`ifdef ALU_MUL_EN
        issue(3'b101, 16'hFFFF, 16'hFFFF, 1'b0);
        seen = 1'b0;
        for (int i = 1; i <= W; i++) begin
            if (i == 4) begin
                op = 3'b000; a = 16'h0001; b = 16'h0001; start = 1'b1;
            end
            step();
            start = 1'b0;
            if (done || !busy) seen = 1'b1;
        end
        chk("mul_early", seen, 1'b0);
        step();
        chk("mul_done",  {busy, done, err}, 3'b010);
        chk("mul_hi",    mul_acc_out, 16'hFFFE);
        chk("mul_lo",    acc_out, 16'h0001);
        chk("mul_flags", {carry, overflow, zero}, 3'b000);
`endif

        issue(3'b000, 16'h0003, 16'h0004, 1'b0);
        step();
        chk("chain1_done", done, 1'b1);
        chk("chain1_acc",  acc_out, 16'h0007);
        issue(3'b000, 16'h00FF, 16'h000A, 1'b1);
        chk("chain2_k",    {busy, done}, 2'b10);
        step();
        chk("chain2_done", done, 1'b1);
        chk("chain2_acc",  acc_out, 16'h0011);
        chk("chain2_mul",  mul_acc_out, 16'h0000);

`ifdef ALU_MUL_EN
        issue(3'b101, 16'h1234, 16'h0003, 1'b0);
        for (int i = 0; i < 7; i++) step();
`else
        issue(3'b000, 16'h1234, 16'h0003, 1'b0);
`endif
        chk("rst_pre_busy", busy, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("rst_async_ctl", {busy, done, err}, 3'b000);
        chk("rst_async_acc", acc_out, 16'h0000);
        chk("rst_async_mul", mul_acc_out, 16'h0000);
        chk("rst_async_flg", {carry, overflow, zero}, 3'b000);
        step();
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            step();
            if (done || busy) seen = 1'b1;
        end
        chk("rst_no_done", seen, 1'b0);

        issue(3'b010, 16'hF0F0, 16'hFFFF, 1'b0);
        step();
        chk("xor_done",  done, 1'b1);
        chk("xor_acc",   acc_out, 16'h0F0F);
        chk("xor_flags", {carry, overflow, zero}, 3'b000);

        issue(3'b000, 16'h1200, 16'h0034, 1'b0);
        step();
        chk("pre_rsv_acc", acc_out, 16'h1234);
        issue(3'b111, 16'hAAAA, 16'h5555, 1'b0);
        step();
        chk("rsv_done",  {done, err}, 2'b11);
        chk("rsv_acc",   acc_out, 16'h1234);
        chk("rsv_flags", {carry, overflow, zero}, 3'b000);
        step();
        chk("rsv_err_clr", {done, err}, 2'b00);

`ifndef ALU_MUL_EN
        issue(3'b101, 16'h0002, 16'h0003, 1'b0);
        step();
        chk("mul_off_done", {busy, done, err}, 3'b011);
        chk("mul_off_acc",  acc_out, 16'h1234);
        chk("mul_off_hi",   mul_acc_out, 16'h0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/param_alu.md
# param_alu

Parametrised, handshaked successor to the team's 16-bit accumulator ALU. It has a generic data width and registered operand capture, and supports ADD/SUB/XOR/AND/OR/PASSB in a single execute cycle. Unsigned MUL runs as an iterative shift-add over WIDTH cycles. It sits between the register file / datapath control and the accumulator consumers. Control issues `start` and waits for `done`, and results can be chained through the accumulator via `use_acc`.

## Interface
- WIDTH, 16, datapath width in bits (≥4).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  request; sampled only when busy=0.
- op  in  3  opcodes: 000 ADD, 001 SUB, 010 XOR, 011 AND, 100 OR, 101 MUL, 110 PASSB, 111 reserved.
- use_acc  in  1  at capture, operand A = acc_out instead of `a`.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse; results valid.
- err  out  1  1 with done for an illegal/unsupported op; 0 otherwise.
- acc_out  out  WIDTH  result, or low half of the MUL product.
- mul_acc_out  out  WIDTH  high half of the MUL product; 0 after non-MUL ops.
- carry  out  1  ADD carry-out; SUB not-borrow (A≥B unsigned).
- overflow  out  1  two's-complement overflow for ADD/SUB.
- zero  out  1  result (full 2·WIDTH product for MUL) equals 0.

## Operation
- The FSM has three states: IDLE, EXEC and MUL.
- IDLE, start=1: capture opA (a or acc_out), opB and op, and set busy=1.
  - Go to MUL if op=MUL is compiled in.
  - Otherwise go to EXEC.
- EXEC: compute the result, write acc_out and the flags, set mul_acc_out=0, pulse done, clear busy and return to IDLE.
- MUL: radix-2 unsigned shift-add with a counter running 0..WIDTH-1, one multiplier bit per cycle.
  - After the final iteration, write {mul_acc_out, acc_out} = opA·opB, set carry=overflow=0, pulse done, clear busy and return to IDLE.
- Flags:
  - SUB computes A + ~B + 1.
  - Logic ops and PASSB force carry=overflow=0.
- Reserved op (or MUL when compiled out):
  - Takes the EXEC path.
  - acc_out, mul_acc_out and flags are unchanged.
  - err=1 together with done.
- start while busy=1 is ignored and has no side effects.
- Widths: all arithmetic is modulo 2^WIDTH except MUL, which keeps 2·WIDTH bits.

## Timing
- Reset (rst=0, async): busy=done=err=0, acc_out=mul_acc_out=0, carry=overflow=zero=0, FSM=IDLE.
- Reset mid-operation discards the in-flight op; no done is produced.
- start sampled at edge k:
  - busy=1 after edge k.
  - Non-MUL: results and done=1 after edge k+1 (latency 2 edges), busy=0 at the same time.
  - MUL: done=1 after edge k+WIDTH+1; busy is high for WIDTH+1 cycles.
- done lasts exactly one cycle. err is valid only while done=1 and is 0 otherwise.
- Back-to-back: in the done cycle busy=0, so a start in that cycle is accepted. With use_acc=1 it sees the just-written acc_out.
- Outputs are held stable between done pulses.

## Configuration
- ALU_MUL_EN defined: the MUL state, counter and shift-add datapath are compiled in.
- ALU_MUL_EN undefined:
  - No multiplier logic is built.
  - op=101 behaves as reserved: 2-edge latency, err=1, outputs unchanged.
  - mul_acc_out is still cleared by the other ops.

## Test plan (WIDTH=16)
- ADD 0x7FFF+0x0001 -> acc_out=0x8000, overflow=1, carry=0, zero=0; done exactly 2 edges after start.
- SUB 0x0005−0x0005 -> acc_out=0x0000, zero=1, carry=1, overflow=0. SUB 0x0003−0x0005 -> 0xFFFE, carry=0.
- MUL 0xFFFF×0xFFFF -> mul_acc_out=0xFFFE, acc_out=0x0001, done 17 edges after start; a start with op=ADD at cycle 5 is ignored.
- Chaining: ADD 3+4, then a start on the done cycle with use_acc=1, op=ADD, b=10 -> acc_out=0x0011, mul_acc_out=0.
- Reset (rst=0) at cycle 8 of a MUL -> all outputs 0 and busy=0 immediately, no done. After release, XOR 0xF0F0^0xFFFF -> 0x0F0F.
- op=111 after ADD result 0x1234 -> done=1 with err=1, acc_out stays 0x1234. With ALU_MUL_EN undefined, op=101 gives the same.
